serv_mem_arbiter: RTL and testbench
===================================

// Module: serv_mem_arbiter
// PURPOSE
//  Shares one external memory port between the core's instruction-fetch and data (load/store) buses.
//  One transaction in flight; read response routed back to the owner; sits between serv_top and memory.
// PARAMETERS
//  DATA_PRIO  1  1: data side wins simultaneous requests; 0: round-robin on last owner
// PORTS
//  clk         in   1   clock, all state updates on rising edge
//  rst         in   1   synchronous active-high reset
//  i_i_ca_adr  in   32  fetch address
//  i_i_ca_vld  in   1   fetch request valid
//  o_i_ca_rdy  out  1   fetch request accepted
//  o_i_rd_dat  out  32  fetch read data
//  o_i_rd_vld  out  1   fetch read data valid
//  i_i_rd_rdy  in   1   fetch side ready for read data
//  i_d_ca_cmd  in   1   data command, 1=write 0=read
//  i_d_ca_adr  in   32  data address
//  i_d_ca_vld  in   1   data request valid
//  o_d_ca_rdy  out  1   data request accepted
//  i_d_dm_dat  in   32  write data
//  i_d_dm_msk  in   4   write byte mask
//  i_d_dm_vld  in   1   write data valid
//  o_d_dm_rdy  out  1   write data accepted
//  o_d_rd_dat  out  32  load read data
//  o_d_rd_vld  out  1   load read data valid
//  i_d_rd_rdy  in   1   data side ready for read data
//  o_m_ca_cmd  out  1   memory command, 1=write
//  o_m_ca_adr  out  32  memory address
//  o_m_ca_vld  out  1   memory request valid
//  i_m_ca_rdy  in   1   memory request accepted
//  o_m_dm_dat  out  32  memory write data
//  o_m_dm_msk  out  4   memory write byte mask
//  o_m_dm_vld  out  1   memory write data valid
//  i_m_dm_rdy  in   1   memory write data accepted
//  i_m_rd_dat  in   32  memory read data
//  i_m_rd_vld  in   1   memory read data valid
//  o_m_rd_rdy  out  1   arbiter ready for memory read data
//  o_busy      out  1   1 when state != IDLE
// BEHAVIOUR
//  - Handshake: transfer on a channel when vld & rdy high on the same rising edge.
//  - States: IDLE, ICA, IRD, DCA, DDM, DRD. Reset (rst=1) -> IDLE next edge, all outputs 0.
//  - Reset mid-operation aborts the transaction; any later response is ignored. Memory is reset in step with the arbiter.
//  - IDLE: no rdy/vld asserted; grant decided on registered state -> 1 cycle latency to o_m_ca_vld.
//  - IDLE -> ICA if only i_i_ca_vld; -> DCA if only i_d_ca_vld. On both: DCA if DATA_PRIO=1, else non-last owner.
//  - Last owner resets to I, so the first tie under round-robin grants D.
//  - ICA: o_m_ca_* = fetch inputs, cmd=0; o_i_ca_rdy = i_m_ca_rdy; on handshake -> IRD.
//  - DCA: o_m_ca_* = data inputs; o_d_ca_rdy = i_m_ca_rdy; on handshake -> DDM if cmd=1, else DRD.
//  - DDM: o_m_dm_* = i_d_dm_*; o_d_dm_rdy = i_m_dm_rdy; on handshake -> IDLE.
//  - IRD/DRD: owner rd_dat/vld = i_m_rd_*; o_m_rd_rdy = owner rd_rdy; on handshake -> IDLE.
//  - Non-owner rdy/vld stay 0; muxed adr/dat/msk/cmd outputs are 0 outside their owning state.
//  - i_m_rd_vld outside IRD/DRD is ignored and o_m_rd_rdy stays 0.
//  - A request held while the other side owns the port stays pending and is granted from IDLE.
// TESTING
//  Fetch 0x8, mem returns 0x00000013 -> o_m_ca_vld 1 cycle after i_i_ca_vld; o_i_rd_dat=0x13, busy clears.
//  Store 0x100 dat 0xDEADBEEF msk 0xF -> m_ca cmd=1, then o_m_dm_dat/msk match; no rd phase; -> IDLE.
//  Fetch+load same cycle: DATA_PRIO=1 -> D first, I next; DATA_PRIO=0 -> D, then I, then alternate.
//  rst asserted in DRD -> IDLE next cycle, all vld/rdy 0, later i_m_rd_vld does not reach o_d_rd_vld.
//  i_m_ca_rdy held 0 for 5 cycles in ICA -> o_m_ca_adr stable, o_i_ca_rdy 0 until accepted.

Source files
------------

// File: rtl/serv_mem_arbiter_if.sv
// serv_mem_arbiter_if
//   Bundles the three buses around serv_mem_arbiter: the fetch requester
//   (i_i_* / o_i_*), the data requester (i_d_* / o_d_*) and the shared
//   memory port (o_m_* / i_m_*), plus the o_busy status flag.
//   Signal names are those of the flat arbiter port list.
//   slave  : arbiter view (drives o_*, samples i_*)
//   master : surrounding system view (drives i_*, samples o_*)
interface serv_mem_arbiter_if;
  // fetch side
  logic [31:0] i_i_ca_adr;
  logic        i_i_ca_vld;
  logic        o_i_ca_rdy;
  logic [31:0] o_i_rd_dat;
  logic        o_i_rd_vld;
  logic        i_i_rd_rdy;
  // data side
  logic        i_d_ca_cmd;
  logic [31:0] i_d_ca_adr;
  logic        i_d_ca_vld;
  logic        o_d_ca_rdy;
  logic [31:0] i_d_dm_dat;
  logic [3:0]  i_d_dm_msk;
  logic        i_d_dm_vld;
  logic        o_d_dm_rdy;
  logic [31:0] o_d_rd_dat;
  logic        o_d_rd_vld;
  logic        i_d_rd_rdy;
  // memory side
  logic        o_m_ca_cmd;
  logic [31:0] o_m_ca_adr;
  logic        o_m_ca_vld;
  logic        i_m_ca_rdy;
  logic [31:0] o_m_dm_dat;
  logic [3:0]  o_m_dm_msk;
  logic        o_m_dm_vld;
  logic        i_m_dm_rdy;
  logic [31:0] i_m_rd_dat;
  logic        i_m_rd_vld;
  logic        o_m_rd_rdy;
  // status
  logic        o_busy;

  modport slave (
    input  i_i_ca_adr, i_i_ca_vld, i_i_rd_rdy,
    output o_i_ca_rdy, o_i_rd_dat, o_i_rd_vld,
    input  i_d_ca_cmd, i_d_ca_adr, i_d_ca_vld, i_d_dm_dat, i_d_dm_msk,
    input  i_d_dm_vld, i_d_rd_rdy,
    output o_d_ca_rdy, o_d_dm_rdy, o_d_rd_dat, o_d_rd_vld,
    output o_m_ca_cmd, o_m_ca_adr, o_m_ca_vld, o_m_dm_dat, o_m_dm_msk,
    output o_m_dm_vld, o_m_rd_rdy,
    input  i_m_ca_rdy, i_m_dm_rdy, i_m_rd_dat, i_m_rd_vld,
    output o_busy
  );

  modport master (
    output i_i_ca_adr, i_i_ca_vld, i_i_rd_rdy,
    input  o_i_ca_rdy, o_i_rd_dat, o_i_rd_vld,
    output i_d_ca_cmd, i_d_ca_adr, i_d_ca_vld, i_d_dm_dat, i_d_dm_msk,
    output i_d_dm_vld, i_d_rd_rdy,
    input  o_d_ca_rdy, o_d_dm_rdy, o_d_rd_dat, o_d_rd_vld,
    input  o_m_ca_cmd, o_m_ca_adr, o_m_ca_vld, o_m_dm_dat, o_m_dm_msk,
    input  o_m_dm_vld, o_m_rd_rdy,
    output i_m_ca_rdy, i_m_dm_rdy, i_m_rd_dat, i_m_rd_vld,
    input  o_busy
  );
endinterface

// File: rtl/serv_mem_arbiter.sv
// serv_mem_arbiter
//   Shares one external memory port between the core's instruction-fetch
//   bus and its data (load/store) bus. Exactly one transaction is in flight;
//   read data is steered back to whichever side owns the port.
// Parameters
//   DATA_PRIO  1: data side wins simultaneous requests
//              0: simultaneous requests alternate on the last owner
// Ports
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  serv_mem_arbiter_if.slave: fetch, data and memory channels + o_busy
module serv_mem_arbiter #(
  parameter int unsigned DATA_PRIO = 1
) (
  input  logic               clk,
  input  logic               rst,
  serv_mem_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    ICA,
    IRD,
    DCA,
    DDM,
    DRD
  } state_t;

  state_t state;
  logic   last_d;   // 1: data side owned the port most recently
  logic   grant_d;

  // Data wins when alone, when prioritised, or when fetch went last.
  always_comb begin
    grant_d = bus.i_d_ca_vld &&
              (!bus.i_i_ca_vld || (DATA_PRIO != 0) || !last_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      last_d <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state  <= DCA;
            last_d <= 1'b1;
          end else if (bus.i_i_ca_vld) begin
            state  <= ICA;
            last_d <= 1'b0;
          end
        end
        ICA: begin
          if (bus.i_i_ca_vld && bus.i_m_ca_rdy) begin
            state <= IRD;
          end
        end
        IRD: begin
          if (bus.i_m_rd_vld && bus.i_i_rd_rdy) begin
            state <= IDLE;
          end
        end
        DCA: begin
          if (bus.i_d_ca_vld && bus.i_m_ca_rdy) begin
            state <= bus.i_d_ca_cmd ? DDM : DRD;
          end
        end
        DDM: begin
          if (bus.i_d_dm_vld && bus.i_m_dm_rdy) begin
            state <= IDLE;
          end
        end
        DRD: begin
          if (bus.i_m_rd_vld && bus.i_d_rd_rdy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Channel steering depends only on the registered state; everything that
  // is not owned in the current state is held at zero.
  always_comb begin
    bus.o_i_ca_rdy = 1'b0;
    bus.o_i_rd_dat = '0;
    bus.o_i_rd_vld = 1'b0;
    bus.o_d_ca_rdy = 1'b0;
    bus.o_d_dm_rdy = 1'b0;
    bus.o_d_rd_dat = '0;
    bus.o_d_rd_vld = 1'b0;
    bus.o_m_ca_cmd = 1'b0;
    bus.o_m_ca_adr = '0;
    bus.o_m_ca_vld = 1'b0;
    bus.o_m_dm_dat = '0;
    bus.o_m_dm_msk = '0;
    bus.o_m_dm_vld = 1'b0;
    bus.o_m_rd_rdy = 1'b0;
    bus.o_busy     = (state != IDLE);
    case (state)
      ICA: begin
        bus.o_m_ca_adr = bus.i_i_ca_adr;
        bus.o_m_ca_vld = bus.i_i_ca_vld;
        bus.o_i_ca_rdy = bus.i_m_ca_rdy;
      end
      DCA: begin
        bus.o_m_ca_cmd = bus.i_d_ca_cmd;
        bus.o_m_ca_adr = bus.i_d_ca_adr;
        bus.o_m_ca_vld = bus.i_d_ca_vld;
        bus.o_d_ca_rdy = bus.i_m_ca_rdy;
      end
      DDM: begin
        bus.o_m_dm_dat = bus.i_d_dm_dat;
        bus.o_m_dm_msk = bus.i_d_dm_msk;
        bus.o_m_dm_vld = bus.i_d_dm_vld;
        bus.o_d_dm_rdy = bus.i_m_dm_rdy;
      end
      IRD: begin
        bus.o_i_rd_dat = bus.i_m_rd_dat;
        bus.o_i_rd_vld = bus.i_m_rd_vld;
        bus.o_m_rd_rdy = bus.i_i_rd_rdy;
      end
      DRD: begin
        bus.o_d_rd_dat = bus.i_m_rd_dat;
        bus.o_d_rd_vld = bus.i_m_rd_vld;
        bus.o_m_rd_rdy = bus.i_d_rd_rdy;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serv_mem_arbiter.sv
`timescale 1ns/1ps
// Testbench for serv_mem_arbiter. Two instances: u[0] with DATA_PRIO=1 and
// u[1] with DATA_PRIO=0. Each instance has its own requesters, a small
// memory responder and a monitor that pops expected transactions.
module tb_serv_mem_arbiter;

  typedef struct packed {
    logic        cmd;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  msk;
  } req_t;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic stall   = 1'b0;  // holds i_m_ca_rdy low
  logic hold_rd = 1'b0;  // delays read responses
  logic inject  = 1'b0;  // drives a stray i_m_rd_vld

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    serv_mem_arbiter_if bus ();

    serv_mem_arbiter #(.DATA_PRIO((g == 0) ? 1 : 0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );

    logic [141:0] outs;
    assign outs = {bus.o_busy, bus.o_m_ca_vld, bus.o_i_ca_rdy, bus.o_d_ca_rdy,
                   bus.o_m_dm_vld, bus.o_d_dm_rdy, bus.o_m_rd_rdy, bus.o_i_rd_vld,
                   bus.o_d_rd_vld, bus.o_m_ca_cmd, bus.o_m_ca_adr, bus.o_m_dm_dat,
                   bus.o_m_dm_msk, bus.o_i_rd_dat, bus.o_d_rd_dat};

    logic [31:0] fq[$];
    req_t        dq[$];
    logic [34:0] exp_ca[$];  // {i_ca_rdy, d_ca_rdy, cmd, adr}
    logic [36:0] exp_dm[$];  // {d_dm_rdy, dat, msk}
    logic [65:0] exp_rd[$];  // {i_rd_vld, d_rd_vld, i_rd_dat, d_rd_dat}
    logic [31:0] mem [128];

    logic i_hs = 1'b0, d_hs = 1'b0, dm_hs = 1'b0, ca_hs = 1'b0;
    logic mdm_hs = 1'b0, rd_hs = 1'b0, quiet = 1'b0, ca_cmd = 1'b0;
    logic [31:0] ca_adr = '0, mdm_dat = '0;
    logic [3:0]  mdm_msk = '0;

    // Monitor: sampled mid-cycle; flags describe the coming rising edge.
    initial begin : monitor
      forever begin
        @(negedge clk);
        i_hs    = bus.i_i_ca_vld & bus.o_i_ca_rdy;
        d_hs    = bus.i_d_ca_vld & bus.o_d_ca_rdy;
        dm_hs   = bus.i_d_dm_vld & bus.o_d_dm_rdy;
        ca_hs   = bus.o_m_ca_vld & bus.i_m_ca_rdy;
        mdm_hs  = bus.o_m_dm_vld & bus.i_m_dm_rdy;
        rd_hs   = bus.i_m_rd_vld & bus.o_m_rd_rdy;
        ca_cmd  = bus.o_m_ca_cmd;
        ca_adr  = bus.o_m_ca_adr;
        mdm_dat = bus.o_m_dm_dat;
        mdm_msk = bus.o_m_dm_msk;
        if (!rst) begin
          if (ca_hs) begin
            if (exp_ca.size() == 0)
              chk($sformatf("u%0d_cmd_pending", g), 160'(exp_ca.size()), 160'd1);
            else
              chk($sformatf("u%0d_cmd", g),
                  160'({bus.o_i_ca_rdy, bus.o_d_ca_rdy, bus.o_m_ca_cmd, bus.o_m_ca_adr}),
                  160'(exp_ca.pop_front()));
          end
          if (mdm_hs) begin
            if (exp_dm.size() == 0)
              chk($sformatf("u%0d_wdata_pending", g), 160'(exp_dm.size()), 160'd1);
            else
              chk($sformatf("u%0d_wdata", g),
                  160'({bus.o_d_dm_rdy, bus.o_m_dm_dat, bus.o_m_dm_msk}),
                  160'(exp_dm.pop_front()));
          end
          if (rd_hs) begin
            if (exp_rd.size() == 0)
              chk($sformatf("u%0d_rdata_pending", g), 160'(exp_rd.size()), 160'd1);
            else
              chk($sformatf("u%0d_rdata", g),
                  160'({bus.o_i_rd_vld, bus.o_d_rd_vld, bus.o_i_rd_dat, bus.o_d_rd_dat}),
                  160'(exp_rd.pop_front()));
          end
        end
        quiet = !bus.o_busy && !bus.i_i_ca_vld && !bus.i_d_ca_vld && !bus.i_d_dm_vld &&
                !bus.i_m_rd_vld && fq.size() == 0 && dq.size() == 0 &&
                exp_ca.size() == 0 && exp_dm.size() == 0 && exp_rd.size() == 0;
      end
    end

    // Requesters and memory responder, updated just after each rising edge.
    initial begin : drive
      req_t        r;
      logic        rd_pend, rd_out;
      logic [31:0] rd_dat, rd_q, wr_adr;
      rd_pend = 1'b0;
      rd_out  = 1'b0;
      rd_dat  = '0;
      rd_q    = '0;
      wr_adr  = '0;
      for (int w = 0; w < 128; w++) mem[w] = 32'hA000_0000 | 32'(w);
      mem[2] = 32'h0000_0013;
      bus.i_i_ca_adr = '0;
      bus.i_i_ca_vld = 1'b0;
      bus.i_i_rd_rdy = 1'b1;
      bus.i_d_ca_cmd = 1'b0;
      bus.i_d_ca_adr = '0;
      bus.i_d_ca_vld = 1'b0;
      bus.i_d_dm_dat = '0;
      bus.i_d_dm_msk = '0;
      bus.i_d_dm_vld = 1'b0;
      bus.i_d_rd_rdy = 1'b1;
      bus.i_m_ca_rdy = 1'b1;
      bus.i_m_dm_rdy = 1'b1;
      bus.i_m_rd_dat = '0;
      bus.i_m_rd_vld = 1'b0;
      forever begin
        @(posedge clk);
        #1;
        bus.i_m_ca_rdy = !stall;
        if (rst) begin
          bus.i_i_ca_vld = 1'b0;
          bus.i_d_ca_vld = 1'b0;
          bus.i_d_dm_vld = 1'b0;
          rd_pend = 1'b0;
          rd_out  = 1'b0;
        end else begin
          if (i_hs) bus.i_i_ca_vld = 1'b0;
          if (!bus.i_i_ca_vld && fq.size() != 0) begin
            bus.i_i_ca_adr = fq.pop_front();
            bus.i_i_ca_vld = 1'b1;
          end
          if (d_hs)  bus.i_d_ca_vld = 1'b0;
          if (dm_hs) bus.i_d_dm_vld = 1'b0;
          if (!bus.i_d_ca_vld && !bus.i_d_dm_vld && dq.size() != 0) begin
            r = dq.pop_front();
            bus.i_d_ca_cmd = r.cmd;
            bus.i_d_ca_adr = r.adr;
            bus.i_d_dm_dat = r.dat;
            bus.i_d_dm_msk = r.msk;
            bus.i_d_ca_vld = 1'b1;
            bus.i_d_dm_vld = r.cmd;
          end
          if (rd_hs) rd_out = 1'b0;
          if (ca_hs && !ca_cmd) begin
            rd_dat  = mem[ca_adr[8:2]];
            rd_pend = 1'b1;
          end
          if (ca_hs && ca_cmd) wr_adr = ca_adr;
          if (mdm_hs) begin
            for (int b = 0; b < 4; b++)
              if (mdm_msk[b]) mem[wr_adr[8:2]][8*b +: 8] = mdm_dat[8*b +: 8];
          end
          if (rd_pend && !hold_rd) begin
            rd_q    = rd_dat;
            rd_out  = 1'b1;
            rd_pend = 1'b0;
          end
        end
        bus.i_m_rd_vld = rd_out | inject;
        bus.i_m_rd_dat = inject ? 32'hBAD0_BAD0 : (rd_out ? rd_q : '0);
      end
    end
  end

  task automatic push_f(input int g, input logic [31:0] adr);
    if (g == 0) u[0].fq.push_back(adr); else u[1].fq.push_back(adr);
  endtask

  task automatic push_d(input int g, input logic cmd, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] msk);
    req_t r;
    r = '{cmd: cmd, adr: adr, dat: dat, msk: msk};
    if (g == 0) u[0].dq.push_back(r); else u[1].dq.push_back(r);
  endtask

  task automatic exp_ca(input int g, input logic [34:0] v);
    if (g == 0) u[0].exp_ca.push_back(v); else u[1].exp_ca.push_back(v);
  endtask

  task automatic exp_dm(input int g, input logic [36:0] v);
    if (g == 0) u[0].exp_dm.push_back(v); else u[1].exp_dm.push_back(v);
  endtask

  task automatic exp_rd(input int g, input logic [65:0] v);
    if (g == 0) u[0].exp_rd.push_back(v); else u[1].exp_rd.push_back(v);
  endtask

  task automatic exp_fetch(input int g, input logic [31:0] adr, input logic [31:0] dat);
    exp_ca(g, {1'b1, 1'b0, 1'b0, adr});
    exp_rd(g, {1'b1, 1'b0, dat, 32'h0});
  endtask

  task automatic exp_load(input int g, input logic [31:0] adr, input logic [31:0] dat);
    exp_ca(g, {1'b0, 1'b1, 1'b0, adr});
    exp_rd(g, {1'b0, 1'b1, 32'h0, dat});
  endtask

  task automatic exp_store(input int g, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] msk);
    exp_ca(g, {1'b0, 1'b1, 1'b1, adr});
    exp_dm(g, {1'b1, dat, msk});
  endtask

  task automatic wait_quiet(input int g);
    int   n;
    logic q;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
      q = (g == 0) ? u[0].quiet : u[1].quiet;
    end while (!q && n < 300);
    chk($sformatf("u%0d_quiet", g), 160'(q), 160'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation did not finish");
  end

  initial begin : stim
    int n;
    // reset: everything idle and zero
    repeat (3) @(negedge clk);
    #2;
    chk("reset_u0", 160'(u[0].outs), 160'd0);
    chk("reset_u1", 160'(u[1].outs), 160'd0);
    rst = 1'b0;

    // fetch 0x8 -> 0x13, one cycle from fetch request to memory request
    push_f(0, 32'h8);
    exp_fetch(0, 32'h8, 32'h13);
    @(negedge clk);
    #2;
    chk("lat_idle", 160'({u[0].bus.i_i_ca_vld, u[0].bus.o_m_ca_vld}), 160'b10);
    @(negedge clk);
    #2;
    chk("lat_ica", 160'({u[0].bus.o_m_ca_vld, u[0].bus.o_m_ca_adr}), 160'({1'b1, 32'h8}));
    wait_quiet(0);

    // full store, no read phase, then read it back
    push_d(0, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF);
    exp_store(0, 32'h100, 32'hDEAD_BEEF, 4'hF);
    wait_quiet(0);
    chk("store_busy", 160'(u[0].bus.o_busy), 160'd0);
    push_d(0, 1'b0, 32'h100, 32'h0, 4'h0);
    exp_load(0, 32'h100, 32'hDEAD_BEEF);
    wait_quiet(0);

    // partial store (bytes 0 and 2) over 0xA0000041
    push_d(0, 1'b1, 32'h104, 32'h1122_3344, 4'h5);
    exp_store(0, 32'h104, 32'h1122_3344, 4'h5);
    push_d(0, 1'b0, 32'h104, 32'h0, 4'h0);
    exp_load(0, 32'h104, 32'hA022_0044);
    wait_quiet(0);

    // two fetches and two loads raised together on both instances
    for (int g = 0; g < 2; g++) begin
      push_f(g, 32'h10);
      push_f(g, 32'h14);
      push_d(g, 1'b0, 32'h40, 32'h0, 4'h0);
      push_d(g, 1'b0, 32'h44, 32'h0, 4'h0);
    end
    exp_load(0, 32'h40, 32'hA000_0010);
    exp_load(0, 32'h44, 32'hA000_0011);
    exp_fetch(0, 32'h10, 32'hA000_0004);
    exp_fetch(0, 32'h14, 32'hA000_0005);
    exp_load(1, 32'h40, 32'hA000_0010);
    exp_fetch(1, 32'h10, 32'hA000_0004);
    exp_load(1, 32'h44, 32'hA000_0011);
    exp_fetch(1, 32'h14, 32'hA000_0005);
    wait_quiet(0);
    wait_quiet(1);

    // memory stalls the command channel for five cycles
    stall = 1'b1;
    push_f(0, 32'h20);
    exp_fetch(0, 32'h20, 32'hA000_0008);
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!u[0].bus.o_m_ca_vld && n < 20);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_%0d", i),
          160'({u[0].bus.o_m_ca_vld, u[0].bus.o_i_ca_rdy, u[0].bus.o_m_ca_adr}),
          160'({1'b1, 1'b0, 32'h20}));
      @(negedge clk);
      #2;
    end
    stall = 1'b0;
    wait_quiet(0);

    // reset while a load waits for its data; late responses are dropped
    hold_rd = 1'b1;
    push_d(0, 1'b0, 32'h48, 32'h0, 4'h0);
    exp_ca(0, {1'b0, 1'b1, 1'b0, 32'h48});
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!u[0].bus.o_m_rd_rdy && n < 20);
    chk("drd_reached", 160'({u[0].bus.o_busy, u[0].bus.o_m_rd_rdy}), 160'b11);
    rst = 1'b1;
    @(negedge clk);
    #2;
    chk("rst_in_drd", 160'(u[0].outs), 160'd0);
    rst     = 1'b0;
    hold_rd = 1'b0;
    inject  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #2;
      chk($sformatf("stray_rd_%0d", i),
          160'({u[0].bus.i_m_rd_vld, u[0].bus.o_d_rd_vld, u[0].bus.o_i_rd_vld,
                u[0].bus.o_m_rd_rdy, u[0].bus.o_busy}),
          160'b10000);
    end
    inject = 1'b0;
    wait_quiet(0);

    // port still usable after the abort
    push_f(0, 32'h8);
    exp_fetch(0, 32'h8, 32'h13);
    wait_quiet(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
